// File: rtl/world_clock_core.sv
// 24-hour time-of-day clock with manual field setting, an independent stopwatch
// and a per-zone hour offset on the registered display outputs.
module world_clock_core #(
    parameter int unsigned          TICKS_PER_SEC = 1000000,
    parameter int unsigned          CNT_W         = 20,
    parameter int unsigned          N_ZONES       = 5,
    parameter int unsigned          ZONE_W        = 3,
    parameter logic [5*N_ZONES-1:0] ZONE_OFFSETS  = {5'd8, 5'd16, 5'd23, 5'd11, 5'd0}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              increment,
    input  logic              decrement,
    input  logic              stp,
    input  logic [ZONE_W-1:0] zone,
    input  logic              sw_sel,
    input  logic              sw_run,
    input  logic              sw_clear,
    output logic [4:0]        hour,
    output logic [5:0]        min,
    output logic [5:0]        sec,
    output logic              sec_tick,
    output logic              sw_overflow
);

    localparam logic [CNT_W-1:0] PRE_TC = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] tod_pre_q, tod_pre_d;
    logic [4:0]       tod_hour_q, tod_hour_d;
    logic [5:0]       tod_min_q, tod_min_d;
    logic [5:0]       tod_sec_q, tod_sec_d;
    logic             tod_tick;
    logic             set_en;

    logic [CNT_W-1:0] sw_pre_q, sw_pre_d;
    logic [4:0]       sw_hour_q, sw_hour_d;
    logic [5:0]       sw_min_q, sw_min_d;
    logic [5:0]       sw_sec_q, sw_sec_d;
    logic             sw_ovf_q, sw_ovf_d;

    logic [4:0]       hour_q, hour_d;
    logic [5:0]       min_q, min_d;
    logic [5:0]       sec_q, sec_d;
    logic             sec_tick_q, sec_tick_d;
    logic [4:0]       zone_off;
    logic [5:0]       hour_sum;

    // Wrapping +/-1 on a field whose range is 0..max.
    function automatic logic [5:0] bump(input logic [5:0] v, input logic [5:0] max,
                                        input logic up);
        if (up) return (v == max) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? max : v - 6'd1;
    endfunction

    always_comb begin
        tod_pre_d  = tod_pre_q;
        tod_hour_d = tod_hour_q;
        tod_min_d  = tod_min_q;
        tod_sec_d  = tod_sec_q;
        tod_tick   = 1'b0;
        set_en     = stp && (mode != 2'b00) && (increment ^ decrement);
        if (stp) begin
            tod_pre_d = '0;
            if (set_en) begin
                case (mode)
                    2'b01:   tod_hour_d = 5'(bump({1'b0, tod_hour_q}, 6'd23, increment));
                    2'b10:   tod_min_d  = bump(tod_min_q, 6'd59, increment);
                    2'b11:   tod_sec_d  = bump(tod_sec_q, 6'd59, increment);
                    default: ;
                endcase
            end
        end else if (tod_pre_q == PRE_TC) begin
            tod_pre_d = '0;
            tod_tick  = 1'b1;
            tod_sec_d = bump(tod_sec_q, 6'd59, 1'b1);
            if (tod_sec_q == 6'd59) begin
                tod_min_d = bump(tod_min_q, 6'd59, 1'b1);
                if (tod_min_q == 6'd59) begin
                    tod_hour_d = 5'(bump({1'b0, tod_hour_q}, 6'd23, 1'b1));
                end
            end
        end else begin
            tod_pre_d = tod_pre_q + 1'b1;
        end
    end

    // The overflow flag gates counting, so the wrap past 23:59:59 never happens.
    always_comb begin
        sw_pre_d  = sw_pre_q;
        sw_hour_d = sw_hour_q;
        sw_min_d  = sw_min_q;
        sw_sec_d  = sw_sec_q;
        sw_ovf_d  = sw_ovf_q;
        if (sw_clear) begin
            sw_pre_d  = '0;
            sw_hour_d = '0;
            sw_min_d  = '0;
            sw_sec_d  = '0;
            sw_ovf_d  = 1'b0;
        end else if (sw_run && !sw_ovf_q) begin
            if (sw_pre_q == PRE_TC) begin
                sw_pre_d = '0;
                sw_sec_d = bump(sw_sec_q, 6'd59, 1'b1);
                if (sw_sec_q == 6'd59) begin
                    sw_min_d = bump(sw_min_q, 6'd59, 1'b1);
                    if (sw_min_q == 6'd59) begin
                        sw_hour_d = 5'(bump({1'b0, sw_hour_q}, 6'd23, 1'b1));
                    end
                end
                sw_ovf_d = (sw_hour_d == 5'd23) && (sw_min_d == 6'd59) && (sw_sec_d == 6'd59);
            end else begin
                sw_pre_d = sw_pre_q + 1'b1;
            end
        end
    end

    always_comb begin
        zone_off = '0;
        for (int i = 0; i < N_ZONES; i++) begin
            if (zone == ZONE_W'(i)) zone_off = ZONE_OFFSETS[5*i +: 5];
        end
        hour_sum   = {1'b0, tod_hour_q} + {1'b0, zone_off};
        hour_d     = 5'((hour_sum >= 6'd24) ? hour_sum - 6'd24 : hour_sum);
        min_d      = tod_min_q;
        sec_d      = tod_sec_q;
        sec_tick_d = tod_tick;
        if (sw_sel) begin
            hour_d = sw_hour_q;
            min_d  = sw_min_q;
            sec_d  = sw_sec_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tod_pre_q  <= '0;
            tod_hour_q <= '0;
            tod_min_q  <= '0;
            tod_sec_q  <= '0;
            sw_pre_q   <= '0;
            sw_hour_q  <= '0;
            sw_min_q   <= '0;
            sw_sec_q   <= '0;
            sw_ovf_q   <= 1'b0;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            tod_pre_q  <= tod_pre_d;
            tod_hour_q <= tod_hour_d;
            tod_min_q  <= tod_min_d;
            tod_sec_q  <= tod_sec_d;
            sw_pre_q   <= sw_pre_d;
            sw_hour_q  <= sw_hour_d;
            sw_min_q   <= sw_min_d;
            sw_sec_q   <= sw_sec_d;
            sw_ovf_q   <= sw_ovf_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign hour        = hour_q;
    assign min         = min_q;
    assign sec         = sec_q;
    assign sec_tick    = sec_tick_q;
    assign sw_overflow = sw_ovf_q;

endmodule

// File: tb/tb_world_clock_core.sv
// Scoreboard bench: u_dut (4 ticks/s) covers time of day, setting, zones and a short
// stopwatch run; u_sw (1 tick/s) runs the stopwatch all the way to overflow in parallel.
module tb_world_clock_core;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       increment = 1'b0, decrement = 1'b0, stp = 1'b0;
    logic [2:0] zone = 3'd0;
    logic       sw_sel = 1'b0, sw_run = 1'b0, sw_clear = 1'b0;
    logic [4:0] hour;
    logic [5:0] min, sec;
    logic       sec_tick, sw_overflow;

    logic       s_rst = 1'b0, s_run = 1'b0, s_clear = 1'b0;
    logic [1:0] s_mode = 2'b00;
    logic       s_inc = 1'b0, s_dec = 1'b0, s_stp = 1'b1, s_sel = 1'b1;
    logic [2:0] s_zone = 3'd0;
    logic [4:0] s_hour;
    logic [5:0] s_min, s_sec;
    logic       s_tick, s_ovf;

    exp_t tick_q[$];
    exp_t chk_q0[$];
    exp_t chk_q1[$];
    logic chk_req0 = 1'b0, chk_req1 = 1'b0;
    logic pending = 1'b0;
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0, ref_cyc = 0;

    world_clock_core #(.TICKS_PER_SEC(4), .CNT_W(2)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .increment(increment), .decrement(decrement),
        .stp(stp), .zone(zone), .sw_sel(sw_sel), .sw_run(sw_run), .sw_clear(sw_clear),
        .hour(hour), .min(min), .sec(sec), .sec_tick(sec_tick), .sw_overflow(sw_overflow)
    );

    world_clock_core #(.TICKS_PER_SEC(1), .CNT_W(1)) u_sw (
        .clk(clk), .rst(s_rst), .mode(s_mode), .increment(s_inc), .decrement(s_dec),
        .stp(s_stp), .zone(s_zone), .sw_sel(s_sel), .sw_run(s_run), .sw_clear(s_clear),
        .hour(s_hour), .min(s_min), .sec(s_sec), .sec_tick(s_tick), .sw_overflow(s_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t mk(int h, int m, int s, int ovf);
        exp_t e;
        e.h = 5'(h); e.m = 6'(m); e.s = 6'(s); e.ovf = 1'(ovf);
        return e;
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp(string tag, logic [4:0] h, logic [5:0] m, logic [5:0] s, logic ovf,
                       exp_t e);
        check({tag, "_hour"}, h, e.h);
        check({tag, "_min"}, m, e.m);
        check({tag, "_sec"}, s, e.s);
        check({tag, "_ovf"}, ovf, e.ovf);
    endtask

    // Display is one cycle behind the internal tick, so tick entries are compared
    // on the negedge after the one where sec_tick was seen.
    always @(negedge clk) begin
        exp_t e;
        if (pending) begin
            if (tick_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_tick: got tick at cycle %0d expected none", cyc);
            end else begin
                e = tick_q.pop_front();
                cmp("tick", hour, min, sec, sw_overflow, e);
            end
        end
        pending = sec_tick;
        if (sec_tick) begin
            check("tick_period", cyc - ref_cyc, 4);
            ref_cyc = cyc;
        end
        if (chk_req0 && chk_q0.size() != 0) begin
            e = chk_q0.pop_front();
            cmp("dut", hour, min, sec, sw_overflow, e);
        end
        if (chk_req1 && chk_q1.size() != 0) begin
            e = chk_q1.pop_front();
            cmp("sw", s_hour, s_min, s_sec, s_ovf, e);
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(logic up);
        if (up) increment = 1'b1; else decrement = 1'b1;
        step(1);
        increment = 1'b0;
        decrement = 1'b0;
    endtask

    task automatic expect0(int h, int m, int s, int ovf);
        step(2);
        chk_q0.push_back(mk(h, m, s, ovf));
        chk_req0 = 1'b1;
        step(1);
        chk_req0 = 1'b0;
    endtask

    task automatic expect1(int h, int m, int s, int ovf);
        step(2);
        chk_q1.push_back(mk(h, m, s, ovf));
        chk_req1 = 1'b1;
        step(1);
        chk_req1 = 1'b0;
    endtask

    task automatic drain(int budget);
        int k = 0;
        while (tick_q.size() != 0 && k < budget) begin
            step(1);
            k++;
        end
        if (tick_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_timeout: got %0d ticks pending expected 0", tick_q.size());
            tick_q.delete();
        end
    endtask

    task automatic main_seq();
        step(3);
        check("rst_hour", hour, 0);
        check("rst_min", min, 0);
        check("rst_sec", sec, 0);
        check("rst_tick", sec_tick, 0);
        check("rst_ovf", sw_overflow, 0);

        // Free run for one minute of ticks.
        for (int i = 1; i <= 60; i++) tick_q.push_back(mk(0, i / 60, i % 60, 0));
        rst = 1'b1;
        ref_cyc = cyc;
        drain(300);
        stp = 1'b1;
        expect0(0, 1, 0, 0);

        // Preset 23:59:59, then exactly one tick to midnight.
        mode = 2'b01; pulse(1'b0);
        mode = 2'b10; pulse(1'b0); pulse(1'b0);
        mode = 2'b11; pulse(1'b0);
        mode = 2'b00;
        expect0(23, 59, 59, 0);
        tick_q.push_back(mk(0, 0, 0, 0));
        stp = 1'b0;
        ref_cyc = cyc;
        drain(20);
        stp = 1'b1;
        expect0(0, 0, 0, 0);

        // Field setting, wrap both ways, simultaneous inc/dec and ignored pulses.
        mode = 2'b10; pulse(1'b0);
        expect0(0, 59, 0, 0);
        increment = 1'b1; decrement = 1'b1;
        step(1);
        increment = 1'b0; decrement = 1'b0;
        expect0(0, 59, 0, 0);
        pulse(1'b1);
        expect0(0, 0, 0, 0);
        mode = 2'b01;
        repeat (4) pulse(1'b0);
        expect0(20, 0, 0, 0);
        mode = 2'b00; pulse(1'b1);
        expect0(20, 0, 0, 0);
        mode = 2'b01;
        stp = 1'b0;
        pulse(1'b1);
        stp = 1'b1;
        mode = 2'b00;
        expect0(20, 0, 0, 0);

        // Offset table by index: 0->0, 1->11, 2->23, 3->16, 4->8, 5..7->0.
        zone = 3'd2; expect0(19, 0, 0, 0);
        zone = 3'd3; expect0(12, 0, 0, 0);
        zone = 3'd1; expect0(7, 0, 0, 0);
        zone = 3'd4; expect0(4, 0, 0, 0);
        zone = 3'd7; expect0(20, 0, 0, 0);
        zone = 3'd5; expect0(20, 0, 0, 0);

        // Short stopwatch runs, viewed with a non-zero zone to show no offset applies.
        zone = 3'd2;
        sw_sel = 1'b1;
        sw_run = 1'b1; step(12); sw_run = 1'b0;
        expect0(0, 0, 3, 0);
        sw_clear = 1'b1; sw_run = 1'b1; step(1); sw_clear = 1'b0; sw_run = 1'b0;
        expect0(0, 0, 0, 0);
        sw_run = 1'b1; step(6); sw_run = 1'b0;
        step(10);
        expect0(0, 0, 1, 0);
        sw_run = 1'b1; step(2); sw_run = 1'b0;
        expect0(0, 0, 2, 0);
        sw_sel = 1'b0;
        zone = 3'd0;

        // Async reset in the middle of a running second.
        tick_q.push_back(mk(20, 0, 1, 0));
        stp = 1'b0;
        ref_cyc = cyc;
        drain(20);
        #3;
        rst = 1'b0;
        #1;
        check("arst_hour", hour, 0);
        check("arst_min", min, 0);
        check("arst_sec", sec, 0);
        check("arst_tick", sec_tick, 0);
        check("arst_ovf", sw_overflow, 0);
        step(3);
        check("arst_hold_sec", sec, 0);
        stp = 1'b1;
        rst = 1'b1;
        expect0(0, 0, 0, 0);
    endtask

    task automatic sw_seq();
        int rel;
        int k = 0;
        step(3);
        s_rst = 1'b1;
        s_run = 1'b1;
        rel = cyc;
        step(3659);
        chk_q1.push_back(mk(1, 0, 58, 0));
        chk_req1 = 1'b1;
        step(1);
        chk_req1 = 1'b0;
        while (!s_ovf && k < 90000) begin
            step(1);
            k++;
        end
        if (!s_ovf) begin
            n_tests++;
            n_fail++;
            $display("FAIL sw_ovf_timeout: got overflow 0 expected 1 within 90000 cycles");
        end else begin
            check("sw_ovf_cycle", cyc - rel, 86399);
        end
        step(5);
        expect1(23, 59, 59, 1);
        check("sw2_tick", s_tick, 0);
        s_clear = 1'b1;
        step(1);
        s_clear = 1'b0;
        s_run = 1'b0;
        expect1(0, 0, 0, 0);
    endtask

    initial begin
        fork
            main_seq();
            sw_seq();
        join
        step(2);
        if (tick_q.size() != 0 || chk_q0.size() != 0 || chk_q1.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL leftover_expect: got %0d entries unchecked expected 0",
                     tick_q.size() + chk_q0.size() + chk_q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
